// File: rtl/echo_seq_pkg.sv
// rtl/echo_seq_pkg.sv - shared state encoding and default widths for the echo sequencer
package echo_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_PUSH   = 2'd3
  } state_t;

  localparam int DIN_W_DEF      = 12;
  localparam int DOUT_W_DEF     = 6;
  localparam int SETTLE_W_DEF   = 8;
  localparam int AVG_LOG2_DEF   = 2;
  localparam int FIFO_DEPTH_DEF = 4;

endpackage

// File: rtl/echo_result_fifo.sv
// rtl/echo_result_fifo.sv - synchronous result FIFO with flush; flush beats push and pop
module echo_result_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 18
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [AW:0]      r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push = push && !flush && (r_count != FULL_CNT);
  assign w_pop  = pop && !flush && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage needs no reset; validity is tracked by the count alone
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= wdata;
  end

  assign rdata = r_mem[r_rptr];
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/echo_seq_ctrl.sv
// rtl/echo_seq_ctrl.sv - drives test vectors onto the echo datapath, settles, averages samples, queues results
module echo_seq_ctrl
  import echo_seq_pkg::*;
#(
  parameter int DIN_W      = DIN_W_DEF,
  parameter int DOUT_W     = DOUT_W_DEF,
  parameter int SETTLE_W   = SETTLE_W_DEF,
  parameter int AVG_LOG2   = AVG_LOG2_DEF,
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    sw_clr,
  input  logic [SETTLE_W-1:0]     cfg_settle,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [DIN_W-1:0]        in_data,
  output logic [DIN_W-1:0]        dut_digital,
  input  logic [DOUT_W-1:0]       dut_analog,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [DIN_W+DOUT_W-1:0] out_data,
  output logic                    busy
);

  localparam int ACC_W = DOUT_W + AVG_LOG2;
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0]    DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [AVG_LOG2:0]   SMP_LAST  = (AVG_LOG2+1)'((1 << AVG_LOG2) - 1);

  state_t                r_state;
  state_t                w_state_nxt;
  logic [DIN_W-1:0]      r_vec;
  logic [DIN_W-1:0]      r_dig;
  logic [SETTLE_W-1:0]   r_settle_cnt;
  logic [AVG_LOG2:0]     r_smp_cnt;
  logic [ACC_W-1:0]      r_acc;
  logic                  w_accept;
  logic                  w_push;
  logic                  w_fifo_empty;
  logic [CNT_W-1:0]      w_fifo_count;
  logic [DOUT_W-1:0]     w_result;

  assign in_ready = (r_state == ST_IDLE) && (w_fifo_count < DEPTH_CNT) && !sw_clr;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_push      = 1'b0;
    case (r_state)
      ST_IDLE:   if (w_accept) w_state_nxt = ST_SETTLE;
      ST_SETTLE: if (r_settle_cnt == '0) w_state_nxt = ST_SAMPLE;
      ST_SAMPLE: if (r_smp_cnt == SMP_LAST) w_state_nxt = ST_PUSH;
      ST_PUSH: begin
        w_push      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default:   w_state_nxt = ST_IDLE;
    endcase
    if (sw_clr) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vec        <= '0;
      r_dig        <= '0;
      r_settle_cnt <= '0;
      r_smp_cnt    <= '0;
      r_acc        <= '0;
    end else if (sw_clr) begin
      r_dig        <= '0;
      r_settle_cnt <= '0;
      r_smp_cnt    <= '0;
      r_acc        <= '0;
    end else begin
      case (r_state)
        ST_IDLE: if (w_accept) begin
          r_vec        <= in_data;
          r_dig        <= in_data;
          r_settle_cnt <= cfg_settle;
        end
        ST_SETTLE: if (r_settle_cnt == '0) begin
          r_acc     <= '0;
          r_smp_cnt <= '0;
        end else begin
          r_settle_cnt <= r_settle_cnt - 1'b1;
        end
        ST_SAMPLE: begin
          r_acc     <= r_acc + ACC_W'(dut_analog);
          r_smp_cnt <= r_smp_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Dropping the low AVG_LOG2 bits is the truncating divide by the sample count
  assign w_result = r_acc[ACC_W-1:AVG_LOG2];

  echo_result_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DIN_W + DOUT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (sw_clr),
    .push  (w_push),
    .wdata ({r_vec, w_result}),
    .pop   (out_ready),
    .rdata (out_data),
    .empty (w_fifo_empty),
    .count (w_fifo_count)
  );

  assign out_valid   = !w_fifo_empty;
  assign dut_digital = r_dig;
  assign busy        = (r_state != ST_IDLE);

endmodule

// File: tb/tb_echo_seq_ctrl.sv
// tb/tb_echo_seq_ctrl.sv - scoreboard bench for echo_seq_ctrl with a timing-level reference model
module tb_echo_seq_ctrl;

  localparam int DIN_W = 12;
  localparam int DOUT_W = 6;
  localparam int SETTLE_W = 8;
  localparam int AVG = 2;
  localparam int NS = 1 << AVG;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw_clr = 1'b0;
  logic [SETTLE_W-1:0] cfg_settle = '0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [DIN_W-1:0] in_data = '0;
  logic [DIN_W-1:0] dut_digital;
  logic [DOUT_W-1:0] dut_analog = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [DIN_W+DOUT_W-1:0] out_data;
  logic busy;

  echo_seq_ctrl #(
    .DIN_W(DIN_W), .DOUT_W(DOUT_W), .SETTLE_W(SETTLE_W), .AVG_LOG2(AVG), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sw_clr(sw_clr), .cfg_settle(cfg_settle),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .dut_digital(dut_digital), .dut_analog(dut_analog),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  logic [DIN_W+DOUT_W-1:0] q[$];
  int sched[int];
  bit have_pend = 0;
  int pend_edge = 0;
  logic [DIN_W+DOUT_W-1:0] pend_exp;
  logic [DIN_W-1:0] model_dig = '0;
  logic [DIN_W-1:0] dig_nxt = '0;
  bit dig_upd = 0;
  bit clr_prev = 0;
  bit mon_en = 0;
  bit use_pat = 0;
  int pat[NS];
  int accepts = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Per cycle: settle model effects of the previous edge, check, drive, then record any accept
  task automatic drive(input bit iv, input logic [DIN_W-1:0] d, input logic [SETTLE_W-1:0] cs,
                       input bit ordy, input bit clr);
    int e;
    int sum;
    int s;
    @(negedge clk);
    if (clr_prev) begin q.delete(); sched.delete(); have_pend = 0; clr_prev = 0; end
    if (have_pend && cyc == pend_edge) begin q.push_back(pend_exp); have_pend = 0; end
    if (dig_upd) begin model_dig = dig_nxt; dig_upd = 0; end
    #1;
    chk("dut_digital", 32'(dut_digital), 32'(model_dig));
    chk("busy", 32'(busy), 32'(have_pend));
    sw_clr = clr; in_valid = iv; in_data = d; cfg_settle = cs; out_ready = ordy;
    dut_analog = sched.exists(cyc + 1) ? 6'(sched[cyc + 1]) : 6'($urandom);
    #1;
    chk("in_ready", 32'(in_ready), 32'(!have_pend && q.size() < DEPTH && !clr));
    if (iv && in_ready) begin
      accepts++;
      e = cyc + 1;
      sum = 0;
      for (int k = 0; k < NS; k++) begin
        s = use_pat ? pat[k] : int'($urandom_range(0, 63));
        sched[e + int'(cs) + 2 + k] = s;
        sum += s;
      end
      pend_exp = {d, 6'(sum >> AVG)};
      pend_edge = e + int'(cs) + 2 + NS;
      have_pend = 1;
      dig_nxt = d; dig_upd = 1;
    end
    if (clr) begin clr_prev = 1; dig_nxt = '0; dig_upd = 1; end
  endtask

  always @(negedge clk) begin
    #3;
    if (mon_en) begin
      chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
      if (out_valid && q.size() != 0) begin
        chk("out_data", 32'(out_data), 32'(q[0]));
        if (out_ready && !sw_clr) void'(q.pop_front());
      end
    end
  end

  task automatic idle(input int n, input bit ordy);
    for (int i = 0; i < n; i++) drive(0, '0, '0, ordy, 0);
  endtask

  int a0;

  initial begin
    repeat (3) @(negedge clk);
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_dut_digital", 32'(dut_digital), 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    mon_en = 1;

    // Single vector with constant analog level
    use_pat = 1;
    for (int k = 0; k < NS; k++) pat[k] = 'h1C;
    drive(1, 12'hA5C, 8'd3, 1, 0);
    idle(14, 1);

    // Averaging truncation: 127 >> 2
    pat[0] = 'h3F; pat[1] = 'h3F; pat[2] = 'h01; pat[3] = 'h00;
    drive(1, 12'h123, 8'd2, 1, 0);
    idle(14, 1);
    use_pat = 0;

    // Backpressure: only DEPTH accepts, then exactly one more per pop
    a0 = accepts;
    for (int i = 0; i < 60; i++) drive(1, 12'($urandom), 8'd0, 0, 0);
    chk("bp_accepts", 32'(accepts - a0), DEPTH);
    drive(0, '0, '0, 1, 0);
    for (int i = 0; i < 30; i++) drive(1, 12'($urandom), 8'd0, 0, 0);
    chk("bp_accepts_after_pop", 32'(accepts - a0), DEPTH + 1);
    idle(20, 1);

    // Settle extremes
    drive(1, 12'h0F0, 8'd0, 1, 0);
    idle(10, 1);
    drive(1, 12'hF0F, 8'hFF, 1, 0);
    idle(270, 1);

    // sw_clr during SETTLE with two queued results
    a0 = accepts;
    for (int i = 0; i < 30; i++) drive((accepts - a0) < 2, 12'($urandom), 8'd0, 0, 0);
    drive(1, 12'h5A5, 8'd20, 0, 0);
    idle(3, 0);
    drive(0, '0, '0, 1, 1);
    idle(2, 1);
    chk("clr_q_empty_out_valid", 32'(out_valid), 0);
    chk("clr_dut_digital", 32'(dut_digital), 0);
    idle(40, 1);

    // Asynchronous reset in the middle of SAMPLE
    drive(1, 12'h3C3, 8'd1, 1, 0);
    idle(3, 1);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    mon_en = 0;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_dut_digital", 32'(dut_digital), 0);
    q.delete(); sched.delete(); have_pend = 0; model_dig = '0; dig_upd = 0; clr_prev = 0;
    in_valid = 0; sw_clr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    mon_en = 1;

    // Randomized traffic
    for (int i = 0; i < 1500; i++)
      drive($urandom_range(0, 2) != 0, 12'($urandom), 8'($urandom_range(0, 6)),
            $urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0);
    idle(40, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
